// File: rtl/ram_example_pkg.sv
// Shared definitions for the ram_example storage block: default widths and
// the 0-MSB address/data word types used by the RTL and the bench.
package ram_example_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;

    // Bit 0 is the MSB in both types, matching the block's port ordering.
    typedef logic [0:ADDR_W_DEF-1] addr_t;
    typedef logic [0:DATA_W_DEF-1] data_t;

endpackage

// File: rtl/ram_example_array.sv
// Storage array for ram_example: one clocked write port with a synchronous
// clear, and an asynchronous read mux driven by the same address.
module ram_example_array
    import ram_example_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [0:ADDR_W-1] addr,
    input  logic [0:DATA_W-1] wdata,
    output logic [0:DATA_W-1] rdata
);

    logic [0:DATA_W-1] mem [0:DEPTH-1];

    // Clear every word on reset, otherwise store wdata when the top enables a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Combinational read of the addressed word; the top registers it.
    always_comb begin
        rdata = mem[addr];
    end

endmodule

// File: rtl/ram_example.sv
// Single-port synchronous RAM with a memory enable. The top resolves the
// reset / enable / write / read priority and owns the registered data_out.
// There is no handshake: every cycle is an independent access, and
// back-to-back reads and writes to any address are always accepted.
module ram_example
    import ram_example_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:ADDR_W-1] addr,
    input  logic              wr,
    input  logic              set_mem,
    input  logic [0:DATA_W-1] data_in,
    output logic [0:DATA_W-1] data_out
);

    logic              we;
    logic [0:DATA_W-1] rdata;

    // A write reaches the array only when enabled and not overridden by reset.
    always_comb begin
        we = !rst && set_mem && wr;
    end

    ram_example_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (data_in),
        .rdata (rdata)
    );

    // Output register: zero on reset or when disabled, write-through on writes,
    // otherwise the word read from the array before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (!set_mem) begin
            data_out <= '0;
        end else if (wr) begin
            data_out <= data_in;
        end else begin
            data_out <= rdata;
        end
    end

endmodule

// File: tb/tb_ram_example.sv
// Bench for ram_example: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural memory model.
module tb_ram_example;
    import ram_example_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    addr_t addr = '0;
    logic  wr = 1'b0;
    logic  set_mem = 1'b0;
    data_t data_in = '0;
    data_t data_out;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: an array of words and the value the output must show.
    logic [3:0] model_mem [8];
    logic [3:0] model_out;
    bit         model_valid = 1'b0;

    ram_example dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr       (wr),
        .set_mem  (set_mem),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model update and per-cycle compare: apply the access rules to the inputs
    // sampled at this edge, then check the registered output just after it.
    always @(posedge clk) begin
        logic       s_rst, s_en, s_wr;
        int         s_a;
        logic [3:0] s_d;
        s_rst = rst;
        s_en  = set_mem;
        s_wr  = wr;
        s_a   = int'(addr);
        s_d   = data_in;
        if (s_rst) begin
            for (int i = 0; i < 8; i++) model_mem[i] = 4'h0;
            model_out   = 4'h0;
            model_valid = 1'b1;
        end else if (!s_en) begin
            model_out = 4'h0;
        end else if (s_wr) begin
            model_mem[s_a] = s_d;
            model_out      = s_d;
        end else begin
            model_out = model_mem[s_a];
        end
        #1;
        if (model_valid) begin
            vectors++;
            if (data_out !== model_out) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t: data_out=%h expected=%h", $time, data_out, model_out);
            end
        end
    end

    // Driver: present one cycle of inputs at the falling edge.
    task automatic cyc(input logic r, input logic s, input logic w,
                       input int a, input logic [3:0] d);
        @(negedge clk);
        rst     = r;
        set_mem = s;
        wr      = w;
        addr    = addr_t'(a);
        data_in = d;
    endtask

    // Hand-computed expectation for the edge following the last cyc().
    task automatic expect_lit(input string name, input logic [3:0] want);
        @(posedge clk);
        #2;
        vectors++;
        if (data_out !== want) begin
            miscompares++;
            $display("FAIL %s: data_out=%h expected=%h", name, data_out, want);
        end
    endtask

    initial begin
        // Reset then read-disabled
        cyc(1, 0, 0, 0, 4'h0);
        expect_lit("reset", 4'h0);
        for (int a = 0; a < 4; a++) begin
            for (int k = 0; k < 2; k++) begin
                cyc(0, 0, 0, a, 4'h0);
                expect_lit("disabled_read", 4'h0);
            end
        end

        // Write/hold sequence
        for (int a = 0; a < 4; a++) begin
            for (int k = 0; k < 2; k++) begin
                cyc(0, 1, 1, a, 4'(a));
                expect_lit("write_through", 4'(a));
            end
            for (int k = 0; k < 2; k++) begin
                cyc(0, 1, 0, a, 4'h0);
                expect_lit("hold_read", 4'(a));
            end
        end

        // Full-array readback
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, i, 4'(15 - i));
        for (int i = 7; i >= 0; i--) begin
            cyc(0, 1, 0, i, 4'h0);
            expect_lit("full_readback", 4'(15 - i));
        end

        // Disabled write ignored
        cyc(0, 1, 1, 5, 4'hA);
        cyc(0, 0, 1, 5, 4'h3);
        expect_lit("disabled_write_out", 4'h0);
        cyc(0, 1, 0, 5, 4'h0);
        expect_lit("disabled_write_kept", 4'hA);

        // Reset mid-operation
        cyc(0, 1, 1, 2, 4'hF);
        cyc(1, 1, 1, 3, 4'h7);
        expect_lit("mid_reset_out", 4'h0);
        cyc(0, 1, 0, 2, 4'h0);
        expect_lit("mid_reset_addr2", 4'h0);
        cyc(0, 1, 0, 3, 4'h0);
        expect_lit("mid_reset_addr3", 4'h0);

        // Enable toggling
        cyc(0, 1, 1, 1, 4'h9);
        cyc(0, 1, 0, 1, 4'h0);
        expect_lit("toggle_on", 4'h9);
        cyc(0, 0, 0, 1, 4'h0);
        expect_lit("toggle_off", 4'h0);
        cyc(0, 1, 0, 1, 4'h0);
        expect_lit("toggle_reon", 4'h9);

        // Randomized traffic checked only by the model
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 7),
                4'($urandom_range(0, 15)));
        end
        cyc(0, 0, 0, 0, 4'h0);
        @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
